// File: rtl/execute_stage_md.sv
// execute_stage_md
// Execute stage of the five-stage MIPS pipeline with an iterative multiply /
// unsigned-divide unit (MDU) and the EX/MEM pipeline register.
//
// Ports
//   clk, reset                         clock, async active-high reset
//   regwriteE, memtoregE, memwriteE    control from ID/EX
//   alucontrolE                        ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   alusrcE, regdstE                   B-operand and destination selects
//   mdE, mdopE                         MDU op request, 0 multiply / 1 divide
//   rd1E, rd2E, signimmE               operands and sign-extended immediate
//   rtE, rdE                           register indices
//   resultW                            writeback result for forwarding
//   forwardAE, forwardBE               forwarding selects
//   busyE                              stall request to the hazard unit
//   writeregE                          combinational destination index
//   regwriteM, memtoregM, memwriteM    registered control
//   aluoutM, writedataM, writeregM     registered result, store data, destination
//
// MDU states
//   state | meaning
//   IDLE  | wait for mdE; latch operands and perform the first iteration
//   RUN   | one shift-add / restoring-divide iteration per cycle
//   DONE  | MDU result drives the stage result, busyE low, back to IDLE
module execute_stage_md #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          memwriteE,
    input  logic [2:0]    alucontrolE,
    input  logic          alusrcE,
    input  logic          regdstE,
    input  logic          mdE,
    input  logic          mdopE,
    input  logic [W-1:0]  rd1E,
    input  logic [W-1:0]  rd2E,
    input  logic [W-1:0]  signimmE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] rdE,
    input  logic [W-1:0]  resultW,
    input  logic [1:0]    forwardAE,
    input  logic [1:0]    forwardBE,
    output logic          busyE,
    output logic [RW-1:0] writeregE,
    output logic          regwriteM,
    output logic          memtoregM,
    output logic          memwriteM,
    output logic [W-1:0]  aluoutM,
    output logic [W-1:0]  writedataM,
    output logic [RW-1:0] writeregM
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

    md_state_t     state;
    logic [CW-1:0] cnt;
    logic          md_op;
    logic [W-1:0]  md_hi;   // product accumulator / partial remainder
    logic [W-1:0]  md_lo;   // multiplier / dividend shifting into quotient
    logic [W-1:0]  md_d;    // shifted multiplicand / divisor

    logic [W-1:0]  srca, fwdb, srcb, alu_y, ex_result, md_result;
    logic [W-1:0]  s_hi, s_lo, s_d, n_hi, n_lo, n_d;
    logic          s_op;
    logic [W:0]    div_sh;

    always_comb begin
        case (forwardAE)
            2'b01:   srca = resultW;
            2'b10:   srca = aluoutM;
            default: srca = rd1E;
        endcase
        case (forwardBE)
            2'b01:   fwdb = resultW;
            2'b10:   fwdb = aluoutM;
            default: fwdb = rd2E;
        endcase
    end

    assign srcb      = alusrcE ? signimmE : fwdb;
    assign writeregE = regdstE ? rdE : rtE;

    always_comb begin
        case (alucontrolE)
            3'b010:  alu_y = srca + srcb;
            3'b110:  alu_y = srca - srcb;
            3'b000:  alu_y = srca & srcb;
            3'b001:  alu_y = srca | srcb;
            3'b111:  alu_y = {{(W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_y = '0;
        endcase
    end

    // One MDU iteration. In IDLE it works on the fresh operands so that the
    // latch cycle already counts as the first of the W iterations.
    always_comb begin
        s_hi   = (state == IDLE) ? '0 : md_hi;
        s_lo   = (state == IDLE) ? (mdopE ? srca : srcb) : md_lo;
        s_d    = (state == IDLE) ? (mdopE ? srcb : srca) : md_d;
        s_op   = (state == IDLE) ? mdopE : md_op;
        div_sh = {s_hi, s_lo[W-1]};
        if (s_op) begin
            n_d = s_d;
            // Remainder stays below the divisor, so the W-bit difference is
            // exact. A zero divisor always subtracts, giving an all-ones quotient.
            if (div_sh >= {1'b0, s_d}) begin
                n_hi = div_sh[W-1:0] - s_d;
                n_lo = {s_lo[W-2:0], 1'b1};
            end else begin
                n_hi = div_sh[W-1:0];
                n_lo = {s_lo[W-2:0], 1'b0};
            end
        end else begin
            n_hi = s_hi + (s_lo[0] ? s_d : '0);
            n_lo = s_lo >> 1;
            n_d  = s_d << 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            md_op <= 1'b0;
            md_hi <= '0;
            md_lo <= '0;
            md_d  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdE) begin
                        md_op <= mdopE;
                        md_hi <= n_hi;
                        md_lo <= n_lo;
                        md_d  <= n_d;
                        cnt   <= CW'(W);
                        state <= RUN;
                    end
                end
                RUN: begin
                    md_hi <= n_hi;
                    md_lo <= n_lo;
                    md_d  <= n_d;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(2))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign md_result = md_op ? md_lo : md_hi;
    assign ex_result = (state == DONE) ? md_result : alu_y;
    assign busyE     = ((state == IDLE) && mdE) || (state == RUN);

    // Bubble while busy: control cleared, data fields simply held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
            aluoutM    <= '0;
            writedataM <= '0;
            writeregM  <= '0;
        end else if (busyE) begin
            regwriteM  <= 1'b0;
            memtoregM  <= 1'b0;
            memwriteM  <= 1'b0;
        end else begin
            regwriteM  <= regwriteE;
            memtoregM  <= memtoregE;
            memwriteM  <= memwriteE;
            aluoutM    <= ex_result;
            writedataM <= fwdb;
            writeregM  <= writeregE;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwriteE, memtoregE, memwriteE, alusrcE, regdstE, mdE, mdopE;
    logic [2:0]  alucontrolE;
    logic [31:0] rd1E, rd2E, signimmE, resultW;
    logic [4:0]  rtE, rdE;
    logic [1:0]  forwardAE, forwardBE;
    logic        busyE, regwriteM, memtoregM, memwriteM;
    logic [4:0]  writeregE, writeregM;
    logic [31:0] aluoutM, writedataM;

    // W=16 instance
    logic        h_regwrite, h_memtoreg, h_memwrite, h_alusrc, h_regdst, h_md, h_mdop;
    logic [2:0]  h_aluctl;
    logic [15:0] h_rd1, h_rd2, h_imm, h_resw;
    logic [4:0]  h_rt, h_rd;
    logic [1:0]  h_fa, h_fb;
    logic        h_busy, h_regwriteM, h_memtoregM, h_memwriteM;
    logic [4:0]  h_writeregE, h_writeregM;
    logic [15:0] h_aluoutM, h_writedataM;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_stage_md #(.W(32), .RW(5)) dut (
        .clk(clk), .reset(reset),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
        .alucontrolE(alucontrolE), .alusrcE(alusrcE), .regdstE(regdstE),
        .mdE(mdE), .mdopE(mdopE), .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE),
        .rtE(rtE), .rdE(rdE), .resultW(resultW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .busyE(busyE), .writeregE(writeregE),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM)
    );

    execute_stage_md #(.W(16), .RW(5)) dut16 (
        .clk(clk), .reset(reset),
        .regwriteE(h_regwrite), .memtoregE(h_memtoreg), .memwriteE(h_memwrite),
        .alucontrolE(h_aluctl), .alusrcE(h_alusrc), .regdstE(h_regdst),
        .mdE(h_md), .mdopE(h_mdop), .rd1E(h_rd1), .rd2E(h_rd2), .signimmE(h_imm),
        .rtE(h_rt), .rdE(h_rd), .resultW(h_resw),
        .forwardAE(h_fa), .forwardBE(h_fb),
        .busyE(h_busy), .writeregE(h_writeregE),
        .regwriteM(h_regwriteM), .memtoregM(h_memtoregM), .memwriteM(h_memwriteM),
        .aluoutM(h_aluoutM), .writedataM(h_writedataM), .writeregM(h_writeregM)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rd,
                                            input logic [31:0] resw, input logic [31:0] mval);
        if (sel == 2'b01) return resw;
        if (sel == 2'b10) return mval;
        return rd;
    endfunction

    function automatic logic [31:0] md_ref(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        if (op) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    function automatic logic [15:0] md_ref16(input logic op, input logic [15:0] a, input logic [15:0] b);
        int unsigned p;
        if (op) return (b == 0) ? 16'hFFFF : a / b;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // ---------------- stimulus/measurement helpers (no comparisons) ----------------
    task automatic run_md(input logic [31:0] a, input logic [31:0] b, input logic op, input int chg_at,
                          output int busy_n, output int bubble_bad, output logic [31:0] res,
                          output logic regw_done, output bit timeout);
        bit done;
        @(negedge clk);
        mdE = 1'b1; mdopE = op; rd1E = a; rd2E = b;
        forwardAE = 2'b00; forwardBE = 2'b00; alusrcE = 1'b0; alucontrolE = 3'b010;
        regwriteE = 1'b1; memtoregE = 1'b0; memwriteE = 1'b0;
        busy_n = 0; bubble_bad = 0; done = 0; timeout = 0; res = '0; regw_done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (chg_at != 0 && busy_n == chg_at) begin
                rd1E = 32'd99; forwardAE = 2'b01; resultW = 32'd55;
            end
            #1;
            if (busyE) begin
                busy_n++;
                @(posedge clk); #1;
                if (regwriteM !== 1'b0) bubble_bad++;
            end else begin
                @(posedge clk); #1;
                res = aluoutM; regw_done = regwriteM; done = 1;
            end
        end
        if (!done) timeout = 1;
    endtask

    task automatic run_md16(input logic [15:0] a, input logic [15:0] b, input logic op,
                            output int busy_n, output logic [15:0] res, output bit timeout);
        bit done;
        @(negedge clk);
        h_md = 1'b1; h_mdop = op; h_rd1 = a; h_rd2 = b; h_regwrite = 1'b1;
        busy_n = 0; done = 0; timeout = 0; res = '0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (h_busy) busy_n++;
            else done = 1;
            @(posedge clk); #1;
            if (done) res = h_aluoutM;
        end
        if (!done) timeout = 1;
    endtask

    task automatic md_end();
        @(negedge clk);
        mdE = 1'b0; h_md = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        regwriteE = 0; memtoregE = 0; memwriteE = 0; alucontrolE = 3'b010; alusrcE = 0; regdstE = 0;
        mdE = 0; mdopE = 0; rd1E = 0; rd2E = 0; signimmE = 0; resultW = 0; rtE = 0; rdE = 0;
        forwardAE = 0; forwardBE = 0;
        h_regwrite = 0; h_memtoreg = 0; h_memwrite = 0; h_aluctl = 3'b010; h_alusrc = 0; h_regdst = 0;
        h_md = 0; h_mdop = 0; h_rd1 = 0; h_rd2 = 0; h_imm = 0; h_resw = 0; h_rt = 0; h_rd = 0;
        h_fa = 0; h_fb = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({regwriteM, memtoregM, memwriteM} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl: got %b want 000", {regwriteM, memtoregM, memwriteM}); end
        checks++; if ({aluoutM, writedataM, writeregM} !== 69'd0) begin errors++;
            $display("FAIL reset_data: got %h/%h/%h want 0", aluoutM, writedataM, writeregM); end
        checks++; if (busyE !== 1'b0) begin errors++;
            $display("FAIL reset_busy_idle: got %b want 0", busyE); end
        checks++; if ({h_regwriteM, h_aluoutM, h_writedataM} !== 33'd0) begin errors++;
            $display("FAIL reset_w16: got %b/%h/%h want 0", h_regwriteM, h_aluoutM, h_writedataM); end
        mdE = 1'b1; #1;
        checks++; if (busyE !== 1'b1) begin errors++;
            $display("FAIL reset_busy_md: got %b want 1", busyE); end
        mdE = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_fwd_alu();
        @(negedge clk);
        rd1E = 32'd7; forwardAE = 2'b00; alusrcE = 1'b1; signimmE = 32'd0; alucontrolE = 3'b010;
        regwriteE = 1'b1; mdE = 1'b0;
        @(posedge clk); #1;
        checks++; if (aluoutM !== 32'd7) begin errors++;
            $display("FAIL fwd_setup: got %0d want 7", aluoutM); end
        @(negedge clk);
        rd1E = 32'd5; forwardAE = 2'b10; signimmE = 32'd3;
        @(posedge clk); #1;
        checks++; if (aluoutM !== 32'd10) begin errors++;
            $display("FAIL fwd_aluoutM: got %0d want 10", aluoutM); end
        checks++; if (regwriteM !== 1'b1) begin errors++;
            $display("FAIL fwd_regwrite: got %b want 1", regwriteM); end
        @(negedge clk);
        forwardAE = 2'b11; regwriteE = 1'b0;
        @(posedge clk); #1;
        checks++; if (aluoutM !== 32'd8) begin errors++;
            $display("FAIL fwd_sel11: got %0d want 8", aluoutM); end
        checks++; if (regwriteM !== 1'b0) begin errors++;
            $display("FAIL fwd_regwrite0: got %b want 0", regwriteM); end
    endtask

    task automatic test_alu_random();
        logic [31:0] exp_m, a, bf, b, exp_next;
        logic [4:0]  exp_wr;
        logic [2:0]  exp_ctl;
        int          bad;
        exp_m = aluoutM === 32'd8 ? 32'd8 : 32'hDEAD_BEEF;  // previous test leaves 8
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mdE = 1'b0;
            rd1E = $urandom; rd2E = $urandom; resultW = $urandom; signimmE = $urandom;
            if (i % 4 == 0) rd1E = 32'h8000_0000 | rd1E;
            alucontrolE = 3'($urandom_range(0, 7));
            forwardAE = 2'($urandom_range(0, 3)); forwardBE = 2'($urandom_range(0, 3));
            alusrcE = 1'($urandom_range(0, 1)); regdstE = 1'($urandom_range(0, 1));
            rtE = 5'($urandom); rdE = 5'($urandom);
            regwriteE = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
            memwriteE = 1'($urandom_range(0, 1));
            a  = fwd_ref(forwardAE, rd1E, resultW, exp_m);
            bf = fwd_ref(forwardBE, rd2E, resultW, exp_m);
            b  = alusrcE ? signimmE : bf;
            exp_next = alu_ref(alucontrolE, a, b);
            exp_wr   = regdstE ? rdE : rtE;
            exp_ctl  = {regwriteE, memtoregE, memwriteE};
            #1;
            checks++; if (writeregE !== exp_wr) begin errors++;
                $display("FAIL alu_writeregE[%0d]: got %0d want %0d", i, writeregE, exp_wr); end
            @(posedge clk); #1;
            checks++; if (aluoutM !== exp_next) begin errors++;
                $display("FAIL alu_result[%0d] op=%b: got %h want %h", i, alucontrolE, aluoutM, exp_next); end
            checks++; if (writedataM !== bf) begin errors++;
                $display("FAIL alu_writedata[%0d]: got %h want %h", i, writedataM, bf); end
            checks++; if ({regwriteM, memtoregM, memwriteM, writeregM} !== {exp_ctl, exp_wr}) begin errors++;
                $display("FAIL alu_ctrl[%0d]: got %b/%0d want %b/%0d", i,
                         {regwriteM, memtoregM, memwriteM}, writeregM, exp_ctl, exp_wr); end
            exp_m = exp_next;
        end
        if (bad != 0) errors++;
    endtask

    task automatic check_md(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic op, input int chg_at, input logic [31:0] expv);
        int busy_n, bubble_bad; logic [31:0] res; logic regw; bit to;
        run_md(a, b, op, chg_at, busy_n, bubble_bad, res, regw, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: got timeout want completion", name); end
        checks++; if (busy_n != 32) begin errors++; $display("FAIL %s_busy: got %0d want 32", name, busy_n); end
        checks++; if (bubble_bad != 0) begin errors++; $display("FAIL %s_bubble: got %0d nonzero regwriteM want 0", name, bubble_bad); end
        checks++; if (res !== expv) begin errors++; $display("FAIL %s_result: got %h want %h", name, res, expv); end
        checks++; if (regw !== 1'b1) begin errors++; $display("FAIL %s_regwrite: got %b want 1", name, regw); end
    endtask

    task automatic test_mul();
        check_md("mul_7x6", 32'd7, 32'd6, 1'b0, 0, 32'd42);
        md_end();
    endtask

    task automatic test_div();
        check_md("div_100_7", 32'd100, 32'd7, 1'b1, 0, 32'd14);
        md_end();
        check_md("div_5_0", 32'd5, 32'd0, 1'b1, 0, 32'hFFFF_FFFF);
        md_end();
    endtask

    task automatic test_md_random();
        logic [31:0] a, b; logic op;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; op = 1'(i % 2);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            check_md("md_rand", a, b, op, 0, md_ref(op, a, b));
            md_end();
        end
    endtask

    task automatic test_isolation();
        check_md("isolate_3x4", 32'd3, 32'd4, 1'b0, 5, 32'd12);
        md_end();
    endtask

    task automatic test_reset_midrun();
        check_md("pre_reset_5x5", 32'd5, 32'd5, 1'b0, 0, 32'd25);
        md_end();
        @(negedge clk);
        mdE = 1'b1; mdopE = 1'b0; rd1E = 32'd3; rd2E = 32'd5; forwardAE = 0; forwardBE = 0;
        alusrcE = 0; regwriteE = 1'b1;
        repeat (11) @(posedge clk);   // IDLE edge plus 10 RUN edges
        #2;
        reset = 1'b1; mdE = 1'b0;
        #1;
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b want 0", busyE); end
        checks++; if (aluoutM !== 32'd0) begin errors++; $display("FAIL midrun_aluout: got %h want 0", aluoutM); end
        checks++; if (regwriteM !== 1'b0) begin errors++; $display("FAIL midrun_regwrite: got %b want 0", regwriteM); end
        @(negedge clk); reset = 1'b0;
        check_md("post_reset_2x3", 32'd2, 32'd3, 1'b0, 0, 32'd6);
        md_end();
    endtask

    task automatic test_back_to_back();
        check_md("b2b_mul", 32'd9, 32'd9, 1'b0, 0, 32'd81);
        check_md("b2b_div", 32'd81, 32'd9, 1'b1, 0, 32'd9);
        md_end();
    endtask

    task automatic test_w16();
        int busy_n; logic [15:0] res, a, b, expv; bit to; logic op;
        run_md16(16'h0100, 16'h0100, 1'b0, busy_n, res, to);
        checks++; if (to || busy_n != 16) begin errors++; $display("FAIL w16_mul_busy: got %0d (to=%0d) want 16", busy_n, to); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL w16_mul_trunc: got %h want 0000", res); end
        run_md16(16'h1234, 16'h0012, 1'b1, busy_n, res, to);
        checks++; if (to || busy_n != 16) begin errors++; $display("FAIL w16_b2b_busy: got %0d (to=%0d) want 16", busy_n, to); end
        checks++; if (res !== 16'h0102) begin errors++; $display("FAIL w16_b2b_div: got %h want 0102", res); end
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = (i == 3) ? 16'd0 : 16'($urandom); op = 1'(i % 2);
            if (i == 3) op = 1'b1;
            expv = md_ref16(op, a, b);
            run_md16(a, b, op, busy_n, res, to);
            checks++; if (to || busy_n != 16 || res !== expv) begin errors++;
                $display("FAIL w16_rand op=%b %h,%h: got %h busy=%0d want %h busy=16", op, a, b, res, busy_n, expv); end
        end
        md_end();
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_alu_random();
        test_mul();
        test_div();
        test_md_random();
        test_isolation();
        test_reset_midrun();
        test_back_to_back();
        test_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time limit want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the five-stage pipelined MIPS core. It performs operand forwarding, destination-register selection and single-cycle ALU operations, and adds an iterative multi-cycle multiply/divide unit (MDU). It drives a stall request to the hazard unit while the MDU runs, and it owns the EX/MEM pipeline register, which accepts a bubble on stall. It sits between the ID/EX register and the memory stage.

## Interface
- W, default 32: datapath width in bits; MDU iteration count equals W.
- RW, default 5: register-index width.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- regwriteE, memtoregE, memwriteE  in  1 each  control from ID/EX.
- alucontrolE  in  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed); other codes give 0.
- alusrcE  in  1  selects the B operand: 0 selects the forwarded rd2, 1 selects signimmE.
- regdstE  in  1  selects the write register: 0 selects rtE, 1 selects rdE.
- mdE  in  1  instruction is an MDU op.
- mdopE  in  1  MDU op: 0 multiply (low W bits of the product), 1 unsigned divide (quotient).
- rd1E, rd2E  in  W  register-file operands.
- signimmE  in  W  sign-extended immediate.
- rtE, rdE  in  RW  register indices.
- resultW  in  W  writeback-stage result, used for forwarding.
- forwardAE, forwardBE  in  2  forwarding select: 00 rd, 01 resultW, 10 aluoutM, 11 behaves as 00.
- busyE  out  1  stall request to the hazard unit.
- writeregE  out  RW  combinational destination index.
- regwriteM, memtoregM, memwriteM  out  1 each  registered control outputs.
- aluoutM, writedataM  out  W  registered result and store data.
- writeregM  out  RW  registered destination index.

## Operation
- srcA is the forwardAE mux output. The forwarded B value is the forwardBE mux output, and it also drives writedataE. srcB is the alusrc mux output. writeregE is the regdst mux output.
- When mdE=0, the result is the ALU output. For slt, the result is 1 if srcA<srcB as signed values, otherwise 0.
- The MDU FSM has three states: IDLE, RUN and DONE.
  - IDLE: when mdE=1, latch srcA, srcB and mdopE into internal registers, load the counter with W, and go to RUN.
  - RUN: perform one shift-add (multiply) or one restoring-divide step per cycle and decrement the counter. When the counter reaches 1, go to DONE.
  - DONE: the MDU result is selected as the stage result, and the FSM returns to IDLE on the next edge.
- Multiply returns the low W bits of srcA*srcB, treated as unsigned. Divide returns floor(srcA/srcB).
- Divide by zero returns a quotient of all ones. It must not hang and must not produce X.
- busyE = (IDLE and mdE) or RUN. busyE is 0 in DONE, so the instruction advances on the DONE edge.
- EX/MEM register:
  - When busyE=1, it loads a bubble: regwriteM, memtoregM and memwriteM are 0; the data fields may hold any value.
  - When busyE=0, it loads the stage outputs.
- MDU operands are latched once. Changes on rd1E, rd2E, forward selects or resultW during RUN have no effect on the MDU result.
- The hazard unit holds ID/EX during busyE, so mdE stays 1 through DONE. In DONE, the FSM ignores mdE.

## Timing
- ALU op: result appears on aluoutM one edge after presentation, so the latency is 1.
- MDU op:
  - busyE rises combinationally in the cycle mdE is first seen.
  - busyE stays high for W cycles (the IDLE cycle plus W-1 RUN cycles), then is low for one DONE cycle.
  - aluoutM is valid after the DONE edge. Total occupancy of EX is W+1 cycles.
- An MDU op immediately following an MDU op starts in IDLE on the cycle after DONE. No extra bubble is inserted.
- Reset is asynchronous:
  - All M outputs are cleared to 0, the FSM goes to IDLE, and the counter clears to 0.
  - busyE is therefore 0 unless mdE=1.
  - A reset during RUN aborts the operation and does not write a result.
- No combinational path exists from any M output back to busyE.

## Test plan
- Forwarding and ALU: rd1E=5, aluoutM=7, forwardAE=10, alusrcE=1, signimmE=3, alucontrolE=010 -> aluoutM=10 and regwriteM follows regwriteE after one edge. With forwardAE=11, the same stimulus gives aluoutM=8.
- Multiply: srcA=7, srcB=6, mdE=1, mdopE=0, regwriteE=1, W=32.
  - busyE is high for exactly 32 cycles and regwriteM=0 throughout.
  - On the DONE edge, aluoutM=42 and regwriteM=1.
- Divide: 100/7 -> aluoutM=14. 5/0 -> aluoutM=0xFFFFFFFF with the same 33-cycle occupancy.
- Operand isolation: start the multiply 3*4, then change rd1E to 99 and forwardAE to 01 during RUN -> aluoutM=12.
- Reset mid-run: assert reset at RUN cycle 10 -> busyE, aluoutM and regwriteM go to 0 before the next edge. A following multiply 2*3 completes normally with result 6.
- W=16: multiply 0x0100*0x0100 -> aluoutM=0x0000 (truncated) with busyE high for 16 cycles. Back-to-back multiply then divide completes with no extra idle cycle.
